// File: rtl/ysyx_22041207_mem_arbiter_pkg.sv
// Shared encodings and default widths for the IF/ME memory-port arbiter.
package ysyx_22041207_mem_arbiter_pkg;

    localparam int AW_DEF            = 64;
    localparam int DW_DEF            = 64;
    localparam int MAX_ME_STREAK_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_ME = 1'b1;

endpackage

// File: rtl/ysyx_22041207_mem_arb_pick.sv
// Combinational IF/ME grant selection with the IF starvation counter update.
module ysyx_22041207_mem_arb_pick
    import ysyx_22041207_mem_arbiter_pkg::*;
#(
    parameter int MAX_ME_STREAK = MAX_ME_STREAK_DEF,
    parameter int SW            = $clog2(MAX_ME_STREAK + 1)
) (
    input  logic          idle,
    input  logic          if_req_valid,
    input  logic          if_kill,
    input  logic          me_req_valid,
    input  logic [SW-1:0] streak_q,
    output logic          grant_if,
    output logic          grant_me,
    output logic [SW-1:0] streak_d
);

    logic starve;
    logic if_elig;

    always_comb begin
        starve   = (streak_q == SW'(MAX_ME_STREAK));
        if_elig  = if_req_valid & ~if_kill;
        grant_if = idle & if_elig & (~me_req_valid | starve);
        grant_me = idle & me_req_valid & ~grant_if;
        streak_d = streak_q;
        if (idle) begin
            // A killed IF request still counts as waiting, so the streak keeps growing.
            if (grant_if || !if_req_valid) begin
                streak_d = '0;
            end else if (grant_me && !starve) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

endmodule

// File: rtl/ysyx_22041207_mem_arbiter.sv
// Shares one memory port between IF and ME; one outstanding transaction, ME priority.
module ysyx_22041207_mem_arbiter
    import ysyx_22041207_mem_arbiter_pkg::*;
#(
    parameter int AW            = AW_DEF,
    parameter int DW            = DW_DEF,
    parameter int MAX_ME_STREAK = MAX_ME_STREAK_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [AW-1:0]   if_req_addr,
    input  logic            if_kill,
    output logic            if_resp_valid,
    output logic [DW-1:0]   if_resp_data,
    input  logic            me_req_valid,
    output logic            me_req_ready,
    input  logic [AW-1:0]   me_req_addr,
    input  logic            me_req_wen,
    input  logic [DW-1:0]   me_req_wdata,
    input  logic [DW/8-1:0] me_req_wmask,
    output logic            me_resp_valid,
    output logic [DW-1:0]   me_resp_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_wen,
    output logic [DW-1:0]   mem_req_wdata,
    output logic [DW/8-1:0] mem_req_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_resp_data,
    output logic            busy,
    output logic            owner
);

    localparam int SW = $clog2(MAX_ME_STREAK + 1);
    localparam int MW = DW / 8;

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          kill_q, kill_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [MW-1:0] wmask_q, wmask_d;

    logic grant_if, grant_me, resp_fire;

    ysyx_22041207_mem_arb_pick #(
        .MAX_ME_STREAK (MAX_ME_STREAK),
        .SW            (SW)
    ) u_pick (
        .idle         (state_q == IDLE),
        .if_req_valid (if_req_valid),
        .if_kill      (if_kill),
        .me_req_valid (me_req_valid),
        .streak_q     (streak_q),
        .grant_if     (grant_if),
        .grant_me     (grant_me),
        .streak_d     (streak_d)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        kill_d  = kill_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d = REQ;
                    owner_d = OWN_IF;
                    addr_d  = if_req_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end else if (grant_me) begin
                    state_d = REQ;
                    owner_d = OWN_ME;
                    addr_d  = me_req_addr;
                    wen_d   = me_req_wen;
                    wdata_d = me_req_wdata;
                    wmask_d = me_req_wmask;
                end
            end
            REQ:     if (mem_req_ready) state_d = RESP;
            RESP:    if (mem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Killed IF transactions still run to completion; only the response is dropped.
        if (state_q != IDLE && owner_q == OWN_IF && if_kill) kill_d = 1'b1;
        if (state_d == IDLE) kill_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            kill_q   <= 1'b0;
            streak_q <= '0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            kill_q   <= kill_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    assign resp_fire     = (state_q == RESP) & mem_resp_valid;
    assign if_req_ready  = grant_if;
    assign me_req_ready  = grant_me;
    assign if_resp_valid = resp_fire & (owner_q == OWN_IF) & ~kill_q & ~if_kill;
    assign me_resp_valid = resp_fire & (owner_q == OWN_ME);
    assign if_resp_data  = if_resp_valid ? mem_resp_data : '0;
    assign me_resp_data  = (me_resp_valid && !wen_q) ? mem_resp_data : '0;
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign busy          = (state_q != IDLE);
    assign owner         = owner_q;

endmodule

// File: tb/tb_ysyx_22041207_mem_arbiter.sv
// Directed bench: per-cycle vector table plus a hand-written starvation-guard sequence.
module tb_ysyx_22041207_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0, if_kill = 1'b0;
    logic [63:0] if_req_addr = '0;
    logic        if_req_ready, if_resp_valid;
    logic [63:0] if_resp_data;
    logic        me_req_valid = 1'b0, me_req_wen = 1'b0;
    logic [63:0] me_req_addr = '0, me_req_wdata = '0;
    logic [7:0]  me_req_wmask = '0;
    logic        me_req_ready, me_resp_valid;
    logic [63:0] me_resp_data;
    logic        mem_req_valid, mem_req_wen;
    logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic [63:0] mem_resp_data = '0;
    logic        busy, owner;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_22041207_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_kill(if_kill), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .me_req_valid(me_req_valid), .me_req_ready(me_req_ready), .me_req_addr(me_req_addr),
        .me_req_wen(me_req_wen), .me_req_wdata(me_req_wdata), .me_req_wmask(me_req_wmask),
        .me_resp_valid(me_resp_valid), .me_resp_data(me_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .owner(owner)
    );

    // ectl = {if_req_ready, me_req_ready, mem_req_valid, if_resp_valid, me_resp_valid, busy}
    typedef struct {
        logic rst_n, ifv; logic [63:0] ifa; logic kill, mev; logic [63:0] mea;
        logic wen; logic [63:0] wd; logic [7:0] wm; logic mrdy, mrv; logic [63:0] mrd;
        logic [5:0] ectl; logic eown; logic [63:0] eifd, emed, ema; logic emwen; logic [7:0] emwm;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic ifv, input logic [63:0] ifa, input logic kill,
        input logic mev, input logic [63:0] mea, input logic wen, input logic [63:0] wd,
        input logic [7:0] wm, input logic mrdy, input logic mrv, input logic [63:0] mrd,
        input logic [5:0] ectl, input logic eown, input logic [63:0] eifd,
        input logic [63:0] emed, input logic [63:0] ema, input logic emwen, input logic [7:0] emwm);
        vec_t v;
        v.rst_n = r; v.ifv = ifv; v.ifa = ifa; v.kill = kill; v.mev = mev; v.mea = mea;
        v.wen = wen; v.wd = wd; v.wm = wm; v.mrdy = mrdy; v.mrv = mrv; v.mrd = mrd;
        v.ectl = ectl; v.eown = eown; v.eifd = eifd; v.emed = emed; v.ema = ema;
        v.emwen = emwen; v.emwm = emwm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    localparam logic [63:0] A  = 64'h8000_0000;
    localparam logic [63:0] A2 = 64'h8000_0004;
    localparam logic [63:0] A3 = 64'h8000_0008;
    localparam logic [63:0] B  = 64'h8000_2000;
    localparam logic [63:0] C  = 64'h8000_3000;
    localparam logic [63:0] D  = 64'h8000_1000;
    localparam logic [63:0] W  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] W2 = 64'hA5A5_0000_FFFF_1234;
    localparam logic [63:0] DB = 64'hDEAD_BEEF_CAFE_F00D;

    vec_t vt[26];

    initial begin
        logic [5:0] got_ctl;
        logic       bad, cmpf, got_own;
        logic       isme;
        logic       exp_me[6];

        // reset state
        vt[0]  = mk(0,0,0,0, 0,0,0,0,0, 0,0,0,     6'b000000,0,0,0,0,0,0);
        // IF fetch, zero wait states
        vt[1]  = mk(1,1,A,0, 0,0,0,0,0, 1,0,0,     6'b100000,0,0,0,0,0,0);
        vt[2]  = mk(1,0,0,0, 0,0,0,0,0, 1,0,0,     6'b001001,0,0,0,A,0,0);
        vt[3]  = mk(1,0,0,0, 0,0,0,0,0, 1,1,64'h13,6'b000101,0,64'h13,0,0,0,0);
        vt[4]  = mk(1,0,0,0, 0,0,0,0,0, 0,0,0,     6'b000000,0,0,0,0,0,0);
        // IF killed while REQ stalls three cycles
        vt[5]  = mk(1,1,A2,0,0,0,0,0,0, 0,0,0,     6'b100000,0,0,0,0,0,0);
        vt[6]  = mk(1,0,0,0, 0,0,0,0,0, 0,0,0,     6'b001001,0,0,0,A2,0,0);
        vt[7]  = mk(1,0,0,1, 0,0,0,0,0, 0,0,0,     6'b001001,0,0,0,A2,0,0);
        vt[8]  = mk(1,0,0,0, 0,0,0,0,0, 0,0,0,     6'b001001,0,0,0,A2,0,0);
        vt[9]  = mk(1,0,0,0, 0,0,0,0,0, 1,0,0,     6'b001001,0,0,0,A2,0,0);
        vt[10] = mk(1,0,0,0, 0,0,0,0,0, 0,1,64'h1234,6'b000001,0,0,0,0,0,0);
        vt[11] = mk(1,1,A3,0,0,0,0,0,0, 0,0,0,     6'b100000,0,0,0,0,0,0);
        vt[12] = mk(1,0,0,0, 0,0,0,0,0, 1,0,0,     6'b001001,0,0,0,A3,0,0);
        vt[13] = mk(1,0,0,0, 0,0,0,0,0, 0,1,64'h55,6'b000101,0,64'h55,0,0,0,0);
        // kill blocks IF eligibility in IDLE
        vt[14] = mk(1,1,A,1, 0,0,0,0,0, 1,0,0,     6'b000000,0,0,0,0,0,0);
        vt[15] = mk(1,0,0,0, 0,0,0,0,0, 1,0,0,     6'b000000,0,0,0,0,0,0);
        // ME read
        vt[16] = mk(1,0,0,0, 1,B,0,0,0, 0,0,0,     6'b010000,0,0,0,0,0,0);
        vt[17] = mk(1,0,0,0, 0,0,0,0,0, 1,0,0,     6'b001001,1,0,0,B,0,0);
        vt[18] = mk(1,0,0,0, 0,0,0,0,0, 0,1,DB,    6'b000011,1,0,DB,0,0,0);
        vt[19] = mk(1,0,0,0, 0,0,0,0,0, 0,0,0,     6'b000000,0,0,0,0,0,0);
        // ME write abandoned by reset in RESP
        vt[20] = mk(1,0,0,0, 1,C,1,W,8'hFF, 0,0,0, 6'b010000,0,0,0,0,0,0);
        vt[21] = mk(1,0,0,0, 0,0,0,0,0, 1,0,0,     6'b001001,1,0,0,C,1,8'hFF);
        vt[22] = mk(0,0,0,0, 0,0,0,0,0, 0,0,0,     6'b000000,0,0,0,0,0,0);
        vt[23] = mk(0,0,0,0, 0,0,0,0,0, 0,1,64'h99,6'b000000,0,0,0,0,0,0);
        vt[24] = mk(1,0,0,0, 0,0,0,0,0, 0,1,64'h99,6'b000000,0,0,0,0,0,0);
        vt[25] = mk(1,0,0,0, 0,0,0,0,0, 0,0,0,     6'b000000,0,0,0,0,0,0);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            rst_n = vt[i].rst_n; if_req_valid = vt[i].ifv; if_req_addr = vt[i].ifa;
            if_kill = vt[i].kill; me_req_valid = vt[i].mev; me_req_addr = vt[i].mea;
            me_req_wen = vt[i].wen; me_req_wdata = vt[i].wd; me_req_wmask = vt[i].wm;
            mem_req_ready = vt[i].mrdy; mem_resp_valid = vt[i].mrv; mem_resp_data = vt[i].mrd;
            #1;
            got_ctl = {if_req_ready, me_req_ready, mem_req_valid, if_resp_valid, me_resp_valid, busy};
            got_own = owner & busy;
            cmpf = vt[i].ectl[3] | ~vt[i].rst_n;
            bad = (got_ctl !== vt[i].ectl) || (got_own !== vt[i].eown)
                || (if_resp_data !== vt[i].eifd) || (me_resp_data !== vt[i].emed)
                || (cmpf && ((mem_req_addr !== vt[i].ema) || (mem_req_wen !== vt[i].emwen)
                             || (mem_req_wmask !== vt[i].emwm)));
            checks++;
            if (bad) begin
                errs++;
                $display("FAIL vec%0d: got ctl=%b own=%b ifd=%h med=%h addr=%h wen=%b wm=%h; want ctl=%b own=%b ifd=%h med=%h addr=%h wen=%b wm=%h",
                         i, got_ctl, got_own, if_resp_data, me_resp_data, mem_req_addr, mem_req_wen,
                         mem_req_wmask, vt[i].ectl, vt[i].eown, vt[i].eifd, vt[i].emed, vt[i].ema,
                         vt[i].emwen, vt[i].emwm);
            end
        end

        // Starvation guard: both held; expect 4 ME writes, then IF, then ME.
        exp_me = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int g = 0; g < 6; g++) begin
            isme = exp_me[g];
            @(negedge clk);
            if_req_valid = 1'b1; if_req_addr = A; if_kill = 1'b0;
            me_req_valid = 1'b1; me_req_addr = D; me_req_wen = 1'b1;
            me_req_wdata = W2; me_req_wmask = 8'hFF;
            mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
            #1;
            chk($sformatf("grant%0d_ready", g), {62'd0, if_req_ready, me_req_ready}, {62'd0, ~isme, isme});
            chk($sformatf("grant%0d_idle_busy", g), {63'd0, busy}, 64'd0);
            @(negedge clk);
            #1;
            chk($sformatf("grant%0d_req", g), {61'd0, mem_req_valid, busy, mem_req_wen}, {61'd0, 1'b1, 1'b1, isme});
            chk($sformatf("grant%0d_addr", g), mem_req_addr, isme ? D : A);
            chk($sformatf("grant%0d_wdata", g), mem_req_wdata, isme ? W2 : 64'd0);
            @(negedge clk);
            mem_resp_valid = 1'b1; mem_resp_data = 64'h77;
            #1;
            chk($sformatf("grant%0d_resp_v", g), {62'd0, if_resp_valid, me_resp_valid}, {62'd0, ~isme, isme});
            chk($sformatf("grant%0d_resp_d", g), isme ? me_resp_data : if_resp_data, isme ? 64'd0 : 64'h77);
        end

        @(negedge clk);
        if_req_valid = 1'b0; me_req_valid = 1'b0; mem_resp_valid = 1'b0;
        #1;
        chk("final_idle", {63'd0, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
